// File: rtl/spi_audio_master.sv
// SPI mode-0 master streaming NSAMPLES audio frames, then reading one result frame.
// Ports: clk/reset, start, samp_* source handshake, sck/ss/mosi/miso, busy, result/result_valid/done.
module spi_audio_master #(
  parameter int CLK_DIV      = 4,
  parameter int NSAMPLES     = 2000,
  parameter int SAMPLE_W     = 10,
  parameter int FRAME_W      = 32,
  parameter int PAUSE_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                samp_valid,
  input  logic [SAMPLE_W-1:0] samp_data,
  output logic                samp_ready,
  output logic                sck,
  output logic                ss,
  output logic                mosi,
  input  logic                miso,
  output logic                busy,
  output logic [SAMPLE_W-1:0] result,
  output logic                result_valid,
  output logic                done
);

  localparam int CW   = $clog2(NSAMPLES + 1);
  localparam int TMAX = (PAUSE_CYCLES > CLK_DIV) ? PAUSE_CYCLES : CLK_DIV;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int BW   = $clog2(FRAME_W);

  localparam logic [TW-1:0] DIV_LAST   = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] PAUSE_LAST = TW'(PAUSE_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(FRAME_W - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(NSAMPLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SHIFT,
    S_GAP,
    S_PAUSE,
    S_READ
  } state_e;

  state_e              state_q, state_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [FRAME_W-1:0]  tx_q, tx_d;
  logic [SAMPLE_W-1:0] rx_q, rx_d;
  logic                sck_q, sck_d;
  logic                ss_q, ss_d;
  logic [SAMPLE_W-1:0] result_q, result_d;
  logic                rv_q, rv_d;
  logic                done_q, done_d;
  logic                tick;

  // Only the low SAMPLE_W bits of the read frame matter, so rx keeps just those.
  assign tick         = (tmr_q == DIV_LAST);
  assign samp_ready   = (state_q == S_WAIT);
  assign busy         = (state_q != S_IDLE);
  assign sck          = sck_q;
  assign ss           = ss_q;
  assign mosi         = tx_q[FRAME_W-1];
  assign result       = result_q;
  assign result_valid = rv_q;
  assign done         = done_q;

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    sck_d    = sck_q;
    ss_d     = ss_q;
    result_d = result_q;
    rv_d     = 1'b0;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          ss_d    = 1'b1;
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (samp_valid) begin
          tx_d    = FRAME_W'(samp_data);
          tmr_d   = '0;
          bit_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT, S_READ: begin
        tmr_d = tmr_q + 1'b1;
        if (tick) begin
          tmr_d = '0;
          sck_d = ~sck_q;
          if (!sck_q) begin
            rx_d = {rx_q[SAMPLE_W-2:0], miso};
          end else begin
            tx_d  = tx_q << 1;
            bit_d = bit_q + 1'b1;
            if (bit_q == BIT_LAST) begin
              if (state_q == S_READ) begin
                ss_d     = 1'b0;
                result_d = rx_q;
                rv_d     = 1'b1;
                done_d   = 1'b1;
                state_d  = S_IDLE;
              end else begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                  ss_d    = 1'b0;
                  state_d = S_PAUSE;
                end else begin
                  state_d = S_GAP;
                end
              end
            end
          end
        end
      end
      S_GAP: begin
        tmr_d = tmr_q + 1'b1;
        if (tick) begin
          tmr_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_PAUSE: begin
        tmr_d = tmr_q + 1'b1;
        if (tmr_q == PAUSE_LAST) begin
          // The read frame's first low phase is the ss setup time.
          tmr_d   = '0;
          bit_d   = '0;
          tx_d    = '0;
          ss_d    = 1'b1;
          state_d = S_READ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      tmr_q    <= '0;
      bit_q    <= '0;
      cnt_q    <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      sck_q    <= 1'b0;
      ss_q     <= 1'b0;
      result_q <= '0;
      rv_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      sck_q    <= sck_d;
      ss_q     <= ss_d;
      result_q <= result_d;
      rv_q     <= rv_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_spi_audio_master.sv
// Bench for spi_audio_master: SPI slave model, sample source, directed random steps.
// Ports: none.
module tb_spi_audio_master;

  localparam int DIV = 2;
  localparam int NS  = 4;
  localparam int SW  = 10;
  localparam int FW  = 32;
  localparam int PC  = 20;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          samp_valid = 1'b0;
  logic [SW-1:0] samp_data = '0;
  logic          samp_ready;
  logic          sck, ss, mosi, miso;
  logic          busy;
  logic [SW-1:0] result;
  logic          result_valid, done;

  int checks = 0;
  int failures = 0;

  spi_audio_master #(
    .CLK_DIV(DIV), .NSAMPLES(NS), .SAMPLE_W(SW),
    .FRAME_W(FW), .PAUSE_CYCLES(PC)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .samp_valid(samp_valid), .samp_data(samp_data),
    .samp_ready(samp_ready), .sck(sck), .ss(ss),
    .mosi(mosi), .miso(miso), .busy(busy),
    .result(result), .result_valid(result_valid),
    .done(done)
  );

  always #5 clk = ~clk;

  // slave model: mode 0, records every 32-bit frame seen on mosi
  logic [31:0] rxq[$];
  logic [31:0] sh = '0, sw_word = '0, read_word = '0;
  logic        miso_s = 1'b0, noise = 1'b0;
  logic        sck_p = 1'b0, ss_p = 1'b0;
  int          nfr = 0, bitn = 0, rises = 0, rise_bad = 0;
  int          read_after = -1;

  assign miso = miso_s ^ noise;

  always @(posedge sck or negedge sck or posedge ss or negedge ss) begin
    if (ss === 1'b1 && ss_p !== 1'b1) begin
      bitn = 0;
      sw_word = (nfr == read_after) ? read_word : $urandom;
      miso_s = sw_word[31];
    end else if (sck === 1'b1 && sck_p !== 1'b1) begin
      rises++;
      if (ss !== 1'b1) rise_bad++;
      else begin
        sh = {sh[30:0], mosi};
        bitn++;
        if (bitn == 32) begin
          rxq.push_back(sh);
          nfr++;
          bitn = 0;
        end
      end
    end else if (sck === 1'b0 && sck_p === 1'b1 && ss === 1'b1) begin
      if (bitn == 0) sw_word = (nfr == read_after) ? read_word : $urandom;
      else sw_word = sw_word << 1;
      miso_s = sw_word[31];
    end
    sck_p = sck;
    ss_p = ss;
  end

  // sample source: presents src_arr in order, optional stall before one index
  logic [SW-1:0] src_arr[NS];
  int src_n = 0, src_gen = 0, gen_seen = 0, sent = 0;
  int stall_at = -1, stall_len = 0, stall_left = 0, stall_bad = 0;
  bit rnd_in = 1'b1;

  always @(negedge clk) begin
    if (gen_seen != src_gen) begin
      gen_seen = src_gen;
      sent = 0;
      stall_left = stall_len;
    end
    if (reset !== 1'b1) begin
      samp_valid = rnd_in ? 1'($urandom) : 1'b0;
      samp_data = rnd_in ? SW'($urandom) : '0;
    end else if (sent == stall_at && stall_left > 0 && samp_ready) begin
      samp_valid = 1'b0;
      stall_left--;
      if (sck !== 1'b0 || ss !== 1'b1) stall_bad++;
    end else if (sent < src_n) begin
      samp_valid = 1'b1;
      samp_data = src_arr[sent];
      if (samp_ready) sent++;
    end else begin
      samp_valid = 1'b0;
    end
  end

  // pulse / pause monitor
  int pause_cnt = 0, done_cnt = 0, pulse_bad = 0;
  always @(negedge clk) begin
    if (busy === 1'b1 && ss === 1'b0) pause_cnt++;
    if (done === 1'b1) done_cnt++;
    if (done !== result_valid) pulse_bad++;
  end

  int base_fr, base_rise, base_rb, base_pause, base_done;
  logic [SW-1:0] exp_res;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_src(input bit rnd, input int st_at, input int st_len);
    logic [SW-1:0] fixed[NS];
    fixed[0] = 10'h155; fixed[1] = 10'h2AA;
    fixed[2] = 10'h3FF; fixed[3] = 10'h001;
    for (int i = 0; i < NS; i++)
      src_arr[i] = rnd ? SW'($urandom) : fixed[i];
    src_n = NS;
    stall_at = st_at;
    stall_len = st_len;
    src_gen++;
  endtask

  task automatic begin_utt(input logic [31:0] rw);
    read_word = rw;
    exp_res = rw[SW-1:0];
    base_fr = rxq.size();
    base_rise = rises;
    base_rb = rise_bad;
    base_pause = pause_cnt;
    base_done = done_cnt;
    read_after = nfr + NS;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // called at the negedge where done is seen
  task automatic check_utt(input string tag);
    logic [31:0] obs;
    check({tag, "_result"}, 64'(result), 64'(exp_res));
    check({tag, "_rvalid"}, 64'(result_valid), 64'd1);
    check({tag, "_nframes"}, 64'(rxq.size() - base_fr), 64'(NS + 1));
    for (int i = 0; i <= NS; i++) begin
      obs = (base_fr + i < rxq.size()) ? rxq[base_fr + i] : 'x;
      if (i < NS) check($sformatf("%s_frame%0d", tag, i), 64'(obs),
                        64'(32'(src_arr[i])));
      else check({tag, "_readtx"}, 64'(obs), 64'd0);
    end
    check({tag, "_rises"}, 64'(rises - base_rise), 64'(32 * (NS + 1)));
    check({tag, "_rise_ss_low"}, 64'(rise_bad - base_rb), 64'd0);
    check({tag, "_pause"}, 64'(pause_cnt - base_pause), 64'(PC));
    tick(1);
    check({tag, "_done_1cyc"}, 64'({done, result_valid}), 64'd0);
    check({tag, "_result_hold"}, 64'(result), 64'(exp_res));
  endtask

  initial begin
    bit ok;
    reset = 1'b1;
    start = 1'b0;
    #2 reset = 1'b0;

    // reset with random inputs
    repeat (12) begin
      @(negedge clk);
      start = 1'($urandom);
      noise = 1'($urandom);
      #1 check("reset_outs",
               64'({sck, ss, mosi, samp_ready, busy, result_valid, done, result}),
               64'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    noise = 1'b0;
    rnd_in = 1'b0;
    tick(2);
    check("idle_busy", 64'({busy, ss, sck}), 64'd0);

    // directed samples, stall before sample 3, fixed read word
    load_src(1'b0, 2, 50);
    begin_utt(32'hFFFF_FEAA);
    tick(1);
    pulse_start();
    check("ss_after_start", 64'({ss, busy}), 64'b11);
    wait_done(4000, ok);
    check("u1_done_seen", 64'(ok), 64'd1);
    check("u1_stall_sck_ss", 64'(stall_bad), 64'd0);
    check("u1_stall_taken", 64'(stall_left), 64'd0);
    check_utt("u1");
    check("u1_idle_after", 64'({busy, ss}), 64'd0);

    // reset during the 10th bit of frame 2, then resend from sample 0
    load_src(1'b1, -1, 0);
    begin_utt($urandom);
    tick(1);
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (nfr == base_fr + 1 && bitn == 9) begin
        ok = 1'b1;
        break;
      end
    end
    check("reach_frame2_bit10", 64'(ok), 64'd1);
    #1 reset = 1'b0;
    #1 check("midframe_reset",
             64'({sck, ss, mosi, samp_ready, busy, result_valid, done, result}),
             64'd0);
    @(negedge clk);
    reset = 1'b1;
    src_gen++;
    begin_utt($urandom);
    tick(2);
    pulse_start();
    wait_done(4000, ok);
    check("u2_done_seen", 64'(ok), 64'd1);
    check_utt("u2");

    // start pulse while busy is ignored
    load_src(1'b1, -1, 0);
    begin_utt($urandom);
    tick(1);
    pulse_start();
    tick(100);
    pulse_start();
    wait_done(4000, ok);
    check("u3_done_seen", 64'(ok), 64'd1);
    check_utt("u3");
    tick(20);
    check("u3_no_restart", 64'({busy, ss}), 64'd0);
    check("u3_done_count", 64'(done_cnt - base_done), 64'd1);

    // start held across done restarts back-to-back
    load_src(1'b1, -1, 0);
    begin_utt($urandom);
    tick(1);
    start = 1'b1;
    wait_done(4000, ok);
    check("u4_done_seen", 64'(ok), 64'd1);
    check_utt("u4");
    check("u4_restart", 64'({busy, ss}), 64'b11);
    start = 1'b0;
    begin_utt($urandom);
    load_src(1'b1, -1, 0);
    wait_done(4000, ok);
    check("u5_done_seen", 64'(ok), 64'd1);
    check_utt("u5");
    check("pulse_align", 64'(pulse_bad), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
